// File: rtl/hd_pkg.sv
// Shared types, widths and pointer helpers for the hd_elastic_buffer slice.
// The optional level port (macro HD_BUF_LEVEL_EN) is sized with hd_cnt_w().
package hd_pkg;

    localparam int HD_DEFAULT_DATA_WIDTH = 32;
    localparam int HD_PTR_MAX_W          = 16;

    // Wide container for pointer arithmetic; callers truncate to their own width.
    typedef logic [HD_PTR_MAX_W-1:0] hd_ptr_t;

    function automatic int hd_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wraps from depth-1 to 0 for any depth, power of two or not.
    function automatic hd_ptr_t hd_ptr_inc(input hd_ptr_t ptr, input int depth);
        return (ptr == hd_ptr_t'(depth - 1)) ? '0 : ptr + hd_ptr_t'(1);
    endfunction

endpackage

// File: rtl/hd_buf_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and a
// combinational read port.
module hd_buf_mem
    import hd_pkg::*;
#(
    parameter int DATA_WIDTH = HD_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_ptr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      rd_ptr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr];

endmodule

// File: rtl/hd_elastic_buffer.sv
// DEPTH-entry first-word-fall-through valid/ready elastic buffer with synchronous flush.
// Optional macro HD_BUF_LEVEL_EN adds a registered 'level' output equal to the fill count.
module hd_elastic_buffer
    import hd_pkg::*;
#(
    parameter  int DATA_WIDTH = HD_DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = hd_cnt_w(DEPTH),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_src,
    input  logic                  valid,
    output logic                  ready_output,
    output logic                  valid_output,
    output logic [DATA_WIDTH-1:0] data_dest,
    input  logic                  ready
`ifdef HD_BUF_LEVEL_EN
    ,
    output logic [CNT_W-1:0]      level
`endif
);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] rdata;

    // Upstream ready comes from state and flush only, never from downstream ready.
    assign ready_output = ~rst & ~flush & (count_q != CNT_W'(DEPTH));
    assign valid_output = (count_q != '0);
    assign push         = valid & ready_output;
    assign pop          = valid_output & ready;

    always_comb begin
        // NOTE: every next-state signal is given its held value first, so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = PTR_W'(hd_ptr_inc(hd_ptr_t'(wr_ptr_q), DEPTH));
            if (pop)  rd_ptr_d = PTR_W'(hd_ptr_inc(hd_ptr_t'(rd_ptr_q), DEPTH));
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    hd_buf_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_ptr (wr_ptr_q),
        .wdata  (data_src),
        .rd_ptr (rd_ptr_q),
        .rdata  (rdata)
    );

    assign data_dest = valid_output ? rdata : '0;

`ifdef HD_BUF_LEVEL_EN
    assign level = count_q;
`endif

endmodule
